// File: rtl/conv2_sched.sv
// conv2_sched: schedules one shared 75-tap conv2 sum datapath (3 maps x 5x5)
// across NUM_CH output channels.
//
// For each output pixel the block consumes one window from the conv2 window
// buffer. It then issues NUM_CH channel evaluations, steering the weight bank
// through ch_sel. The results are returned to the calc/ReLU/pool stage as a
// tagged strobe, and a pulse marks the end of the frame.
//
// Optional build macro: CONV2_SCHED_PERF_EN adds the stall_cnt and wait_cnt
// performance counters. These count datapath back-pressure cycles and
// window-starvation cycles.
module conv2_sched #(
  parameter int NUM_CH = 3,
  parameter int OUT_W  = 8,
  parameter int OUT_H  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ROW_W = (OUT_H  > 1) ? $clog2(OUT_H)  : 1,
  localparam int COL_W = (OUT_W  > 1) ? $clog2(OUT_W)  : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             win_valid,
  output logic             win_ack,
  input  logic             out_ready,
  output logic             calc_en,
  output logic [CH_W-1:0]  ch_sel,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             busy,
  output logic             frame_done
`ifdef CONV2_SCHED_PERF_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      wait_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);

  state_t           r_state;
  logic [CH_W-1:0]  r_ch;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  logic             r_out_valid;
  logic [CH_W-1:0]  r_out_ch;
  logic [ROW_W-1:0] r_out_row;
  logic [COL_W-1:0] r_out_col;
  logic             r_frame_done;

  logic w_issue;
  logic w_last_ch;
  logic w_last_pix;
  logic w_start_ok;

  // A start pulse that arrives in the frame_done cycle is dropped. The
  // previous frame is still being reported, so a new frame must wait until
  // the following cycle.
  assign w_start_ok = start && (r_state == S_IDLE) && !r_frame_done;
  assign w_issue    = (r_state == S_CALC) && out_ready;
  assign w_last_ch  = (r_ch == CH_LAST);
  assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Scan FSM: walks the window, channel, column and row for one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ch  <= '0;
          r_row <= '0;
          r_col <= '0;
          if (w_start_ok) r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (win_valid) begin
            r_ch    <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (out_ready) begin
            if (w_last_ch) begin
              r_ch <= '0;
              if (w_last_pix) begin
                r_state <= S_DONE;
              end else begin
                if (r_col == COL_LAST) begin
                  r_col <= '0;
                  r_row <= r_row + ROW_W'(1);
                end else begin
                  r_col <= r_col + COL_W'(1);
                end
                r_state <= S_LOAD;
              end
            end else begin
              r_ch <= r_ch + CH_W'(1);
            end
          end
        end
        S_DONE: begin
          r_ch    <= '0;
          r_row   <= '0;
          r_col   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result tags follow the datapath's one-cycle register: capture on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      r_out_valid <= w_issue;
      if (w_issue) begin
        r_out_ch  <= r_ch;
        r_out_row <= r_row;
        r_out_col <= r_col;
      end
    end
  end

  // Frame-done trails the DONE state by a cycle, so it follows the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_done <= 1'b0;
    else        r_frame_done <= (r_state == S_DONE);
  end

  assign win_ack    = (r_state == S_LOAD) && win_valid;
  assign calc_en    = (r_state == S_CALC);
  assign ch_sel     = r_ch;
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_ch     = r_out_ch;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

`ifdef CONV2_SCHED_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_wait_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count back-pressure and window-starvation cycles; reset on each new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_wait_cnt  <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if ((r_state == S_CALC) && !out_ready) r_stall_cnt <= sat_inc16(r_stall_cnt);
      if ((r_state == S_LOAD) && !win_valid) r_wait_cnt  <= sat_inc16(r_wait_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign wait_cnt  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_conv2_sched.sv
// Bench for conv2_sched. It drives directed and randomized start, window and
// ready traffic. A reference model predicts the result order from the frame
// scan rule: the channel advances fastest, then the column, then the row.
module tb_conv2_sched;
  localparam int NCH  = 3;
  localparam int OW   = 8;
  localparam int OH   = 8;
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RW   = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW   = (OW > 1) ? $clog2(OW) : 1;
  localparam int NRES = NCH * OW * OH;
  localparam int NPIX = OW * OH;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           win_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           win_ack, calc_en, out_valid, busy, frame_done;
  logic [CHW-1:0] ch_sel, out_ch;
  logic [RW-1:0]  out_row;
  logic [CW-1:0]  out_col;
`ifdef CONV2_SCHED_PERF_EN
  logic [15:0]    stall_cnt, wait_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int iss_idx, res_idx, ack_cnt, cyc, last_valid_cyc;
  bit prev_issue;

  always #5 clk = ~clk;

  conv2_sched #(.NUM_CH(NCH), .OUT_W(OW), .OUT_H(OH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_valid(win_valid),
    .win_ack(win_ack), .out_ready(out_ready), .calc_en(calc_en),
    .ch_sel(ch_sel), .out_valid(out_valid), .out_ch(out_ch),
    .out_row(out_row), .out_col(out_col), .busy(busy),
    .frame_done(frame_done)
`ifdef CONV2_SCHED_PERF_EN
    , .stall_cnt(stall_cnt), .wait_cnt(wait_cnt)
`endif
  );

  // Reference scan order: result n is channel n%NCH of pixel n/NCH (row-major).
  function automatic int exp_ch(input int n);  return n % NCH;         endfunction
  function automatic int exp_row(input int n); return (n / NCH) / OW;  endfunction
  function automatic int exp_col(input int n); return (n / NCH) % OW;  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_win_ack"},    32'(win_ack),    0);
    chk({tag, "_calc_en"},    32'(calc_en),    0);
    chk({tag, "_ch_sel"},     32'(ch_sel),     0);
    chk({tag, "_out_valid"},  32'(out_valid),  0);
    chk({tag, "_out_ch"},     32'(out_ch),     0);
    chk({tag, "_out_row"},    32'(out_row),    0);
    chk({tag, "_out_col"},    32'(out_col),    0);
    chk({tag, "_busy"},       32'(busy),       0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  // Protocol/scoreboard monitor, sampled on the falling edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        iss_idx = 0; res_idx = 0; ack_cnt = 0; prev_issue = 1'b0;
      end else begin
        if (win_ack) begin
          chk("ack_needs_valid", 32'(win_valid), 1);
          chk("ack_not_calc",    32'(calc_en),   0);
          chk("ack_order",       32'(iss_idx),   32'(ack_cnt * NCH));
          ack_cnt++;
        end
        chk("valid_latency", 32'(out_valid), 32'(prev_issue));
        if (out_valid) begin
          chk("tag_ch",  32'(out_ch),  32'(exp_ch(res_idx)));
          chk("tag_row", 32'(out_row), 32'(exp_row(res_idx)));
          chk("tag_col", 32'(out_col), 32'(exp_col(res_idx)));
          res_idx++;
          last_valid_cyc = cyc;
        end
        if (calc_en) begin
          chk("ch_sel",       32'(ch_sel),  32'(exp_ch(iss_idx)));
          chk("calc_has_win", 32'(ack_cnt), 32'(iss_idx / NCH + 1));
        end
        prev_issue = calc_en && out_ready;
        if (calc_en && out_ready) iss_idx++;
        if (frame_done) begin
          chk("fd_after_last", 32'(cyc - last_valid_cyc), 1);
          chk("fd_results",    32'(res_idx), NRES);
          chk("fd_acks",       32'(ack_cnt), NPIX);
          iss_idx = 0; res_idx = 0; ack_cnt = 0;
        end
      end
      cyc++;
    end
  endtask

  task automatic run_to_done(input int pv, input int pr, output int cyc_o);
    cyc_o = 0;
    while (!frame_done && cyc_o < 4000) begin
      win_valid = ($urandom_range(0, 99) < pv);
      out_ready = ($urandom_range(0, 99) < pr);
      tick();
      cyc_o++;
    end
    chk("frame_done_seen", 32'(frame_done), 1);
  endtask

  task automatic wait_tag(input int r, input int c, input int ch);
    int n;
    n = 0;
    while (!(out_valid && int'(out_row) == r && int'(out_col) == c && int'(out_ch) == ch) && n < 2000) begin
      tick();
      n++;
    end
    chk("wait_tag_found", 32'(n < 2000), 1);
  endtask

  initial begin
    int c;
    iss_idx = 0; res_idx = 0; ack_cnt = 0; cyc = 0; last_valid_cyc = 0; prev_issue = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
`ifdef CONV2_SCHED_PERF_EN
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_wait_cnt",  32'(wait_cnt),  0);
`endif
    rst_n = 1'b1;
    tick();

    // Full-rate frame: minimum frame length
    win_valid = 1'b1; out_ready = 1'b1;
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    run_to_done(100, 100, c);
    chk("frame_cycles", 32'(c + 1), 32'(NPIX * (NCH + 1) + 2));
    tick();
    chk("fd_one_cycle", 32'(frame_done), 0);
    chk("idle_busy",    32'(busy),       0);

    // Back-pressure at pixel (2,3), channel 1
    win_valid = 1'b1; out_ready = 1'b1;
    pulse_start();
    wait_tag(2, 3, 0);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_calc_en",   32'(calc_en),   1);
      chk("stall_ch_sel",    32'(ch_sel),    1);
      chk("stall_out_valid", 32'(out_valid), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("resume_valid", 32'(out_valid), 1);
    chk("resume_ch",    32'(out_ch),    1);
    chk("resume_row",   32'(out_row),   2);
    chk("resume_col",   32'(out_col),   3);
    run_to_done(100, 100, c);

    // Window starvation in LOAD
    tick();
    win_valid = 1'b0; out_ready = 1'b1;
    pulse_start();
    repeat (10) begin
      chk("starve_ack",  32'(win_ack), 0);
      chk("starve_calc", 32'(calc_en), 0);
      chk("starve_busy", 32'(busy),    1);
      tick();
    end
    win_valid = 1'b1;
    #1;
    chk("starve_ack_on_valid", 32'(win_ack), 1);
    tick();
    chk("ack_single_cycle", 32'(win_ack), 0);
    chk("calc_after_ack",   32'(calc_en), 1);
    run_to_done(100, 100, c);

    // Asynchronous reset in row 4
    tick();
    win_valid = 1'b1; out_ready = 1'b1;
    pulse_start();
    wait_tag(4, 2, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) begin
      tick();
      chk("midreset_no_fd", 32'(frame_done), 0);
    end
    rst_n = 1'b1;
    tick();
    pulse_start();
    tick();
    tick();
    chk("restart_valid", 32'(out_valid), 1);
    chk("restart_ch",    32'(out_ch),    0);
    chk("restart_row",   32'(out_row),   0);
    chk("restart_col",   32'(out_col),   0);
    run_to_done(100, 100, c);

    // start pulses during CALC, in DONE and with frame_done are ignored
    tick();
    win_valid = 1'b1; out_ready = 1'b1;
    pulse_start();
    wait_tag(1, 1, 0);
    pulse_start();
    chk("calc_start_busy", 32'(busy), 1);
    wait_tag(OH - 1, OW - 1, NCH - 1);
    pulse_start();
    chk("done_start_fd",   32'(frame_done), 1);
    chk("done_start_busy", 32'(busy),       0);
    pulse_start();
    chk("fd_start_busy", 32'(busy), 0);
    tick();
    chk("fd_start_idle", 32'(busy), 0);

`ifdef CONV2_SCHED_PERF_EN
    // Performance counters: 4 LOAD waits, then 7 stalls
    win_valid = 1'b0; out_ready = 1'b1;
    pulse_start();
    repeat (4) tick();
    win_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (7) tick();
    out_ready = 1'b1;
    run_to_done(100, 100, c);
    tick();
    chk("perf_stall", 32'(stall_cnt), 7);
    chk("perf_wait",  32'(wait_cnt),  4);
    tick();
    chk("perf_stall_hold", 32'(stall_cnt), 7);
    pulse_start();
    chk("perf_stall_clr", 32'(stall_cnt), 0);
    chk("perf_wait_clr",  32'(wait_cnt),  0);
    run_to_done(100, 100, c);
    tick();
`endif

    // Randomized traffic
    for (int f = 0; f < 4; f++) begin
      int pv, pr;
      pv = $urandom_range(30, 100);
      pr = $urandom_range(30, 100);
      tick();
      pulse_start();
      run_to_done(pv, pr, c);
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
